fp_stim_seq: RTL and testbench

Parametrised, synthesizable operand sequencer for the floating-point MAC benches and FPGA self-test. It produces `{A, B, C}` triples in four fixed phases: basic, random, exhaustive edge-pattern cross product, and closing basic. Operands are delivered over a valid/ready handshake, which replaces event-based signalling. It sits between the bench control and the MAC DUT input ports, and can also be instantiated in hardware.

---
 rtl/fp_stim_pkg.sv | 72 +++++++
 rtl/fp_stim_lfsr.sv | 38 +++
 rtl/fp_stim_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_fp_stim_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_stim_pkg.sv
// Shared types and the edge-pattern operand table for the FP MAC operand sequencer.
package fp_stim_pkg;

    typedef enum logic [1:0] {
        PH_BASIC = 2'd0,
        PH_RAND  = 2'd1,
        PH_EDGE  = 2'd2,
        PH_CLOSE = 2'd3
    } fp_stim_phase_e;

    localparam logic [3:0] EDGE_POS_ZERO = 4'd0;
    localparam logic [3:0] EDGE_NEG_ZERO = 4'd1;
    localparam logic [3:0] EDGE_MAX_SUB  = 4'd2;
    localparam logic [3:0] EDGE_MIN_NORM = 4'd3;
    localparam logic [3:0] EDGE_MAX_FIN  = 4'd4;
    localparam logic [3:0] EDGE_POS_INF  = 4'd5;
    localparam logic [3:0] EDGE_NEG_INF  = 4'd6;
    localparam logic [3:0] EDGE_QNAN     = 4'd7;
    localparam logic [3:0] EDGE_SNAN     = 4'd8;
    localparam logic [3:0] EDGE_POS_ONE  = 4'd9;
    localparam logic [3:0] EDGE_NEG_ONE  = 4'd10;
    localparam logic [3:0] EDGE_POS_TWO  = 4'd11;
    localparam logic [3:0] EDGE_NEG_TWO  = 4'd12;
    localparam logic [3:0] EDGE_POS_HALF = 4'd13;
    localparam logic [3:0] EDGE_NEG_HALF = 4'd14;
    localparam logic [3:0] EDGE_EPS      = 4'd15;

    function automatic logic [63:0] fp_pack(input logic sign, input logic [63:0] exp_v,
                                            input logic [63:0] mant_v, input int exp_w,
                                            input int mant_w);
        logic [63:0] sign_v;
        sign_v = {63'd0, sign};
        return (sign_v << (exp_w + mant_w)) | (exp_v << mant_w) | mant_v;
    endfunction

    // Result is right-aligned in 64 bits; callers truncate to their operand width.
    function automatic logic [63:0] fp_edge_val(input logic [3:0] idx, input int exp_w,
                                                input int mant_w, input int bias);
        logic [63:0] exp_max;
        logic [63:0] mant_max;
        logic [63:0] mant_msb;
        logic [63:0] mant_q;
        logic [63:0] b;
        logic [63:0] val;
        exp_max  = (64'd1 << exp_w) - 64'd1;
        mant_max = (64'd1 << mant_w) - 64'd1;
        mant_msb = 64'd1 << (mant_w - 1);
        mant_q   = 64'd1 << (mant_w - 2);
        b        = 64'(bias);
        case (idx)
            EDGE_POS_ZERO: val = 64'd0;
            EDGE_NEG_ZERO: val = fp_pack(1'b1, 64'd0, 64'd0, exp_w, mant_w);
            EDGE_MAX_SUB:  val = fp_pack(1'b0, 64'd0, mant_max, exp_w, mant_w);
            EDGE_MIN_NORM: val = fp_pack(1'b0, 64'd1, 64'd0, exp_w, mant_w);
            EDGE_MAX_FIN:  val = fp_pack(1'b0, exp_max - 64'd1, mant_max, exp_w, mant_w);
            EDGE_POS_INF:  val = fp_pack(1'b0, exp_max, 64'd0, exp_w, mant_w);
            EDGE_NEG_INF:  val = fp_pack(1'b1, exp_max, 64'd0, exp_w, mant_w);
            EDGE_QNAN:     val = fp_pack(1'b0, exp_max, mant_msb, exp_w, mant_w);
            EDGE_SNAN:     val = fp_pack(1'b0, exp_max, mant_q, exp_w, mant_w);
            EDGE_POS_ONE:  val = fp_pack(1'b0, b, 64'd0, exp_w, mant_w);
            EDGE_NEG_ONE:  val = fp_pack(1'b1, b, 64'd0, exp_w, mant_w);
            EDGE_POS_TWO:  val = fp_pack(1'b0, b + 64'd1, 64'd0, exp_w, mant_w);
            EDGE_NEG_TWO:  val = fp_pack(1'b1, b + 64'd1, 64'd0, exp_w, mant_w);
            EDGE_POS_HALF: val = fp_pack(1'b0, b - 64'd1, 64'd0, exp_w, mant_w);
            EDGE_NEG_HALF: val = fp_pack(1'b1, b - 64'd1, 64'd0, exp_w, mant_w);
            EDGE_EPS:      val = fp_pack(1'b0, 64'(bias - mant_w), 64'd0, exp_w, mant_w);
            default:       val = 64'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/fp_stim_lfsr.sv
// 32-bit Galois LFSR (x^32+x^22+x^2+x+1) with seed load and advance enable.
module fp_stim_lfsr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_i,
    output logic [31:0] state_o
);
    logic [31:0] state_r;
    logic [31:0] next_s;

    // Right-shifting Galois step; the mask carries the polynomial taps.
    always_comb begin
        next_s = {1'b0, state_r[31:1]};
        if (state_r[0]) begin
            next_s = {1'b0, state_r[31:1]} ^ 32'h8020_0003;
        end else begin
            next_s = {1'b0, state_r[31:1]};
        end
    end

    // State register: reset and load both restore the seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= seed_i;
        end else if (load_i) begin
            state_r <= seed_i;
        end else if (adv_i) begin
            state_r <= next_s;
        end else begin
            state_r <= state_r;
        end
    end

    assign state_o = state_r;

endmodule

// File: rtl/fp_stim_seq.sv
// Valid/ready operand sequencer: basic, random, edge cross-product, closing basic.
// Define FP_STIM_SEQ_RAND_EN to build the random phase and its three LFSRs.
module fp_stim_seq #(
    parameter int          XLEN     = 32,
    parameter int          EXP      = 8,
    parameter int          MANT     = 23,
    parameter int          BIAS     = 127,
    parameter int          NUM_RAND = 20,
    parameter logic [31:0] SEED     = 32'h1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [XLEN-1:0] a_o,
    output logic [XLEN-1:0] b_o,
    output logic [XLEN-1:0] c_o,
    output logic [1:0]      phase_o,
    output logic [15:0]     count_o,
    output logic            done_o
);
    import fp_stim_pkg::*;

    generate
        if (XLEN != 1 + EXP + MANT) begin : g_bad_xlen
            $error("fp_stim_seq: XLEN must equal 1+EXP+MANT");
        end
        if (MANT < 2) begin : g_bad_mant
            $error("fp_stim_seq: MANT must be at least 2");
        end
        if (SEED == 32'h0) begin : g_bad_seed
            $error("fp_stim_seq: SEED must be non-zero");
        end
        if (NUM_RAND < 0) begin : g_bad_nrand
            $error("fp_stim_seq: NUM_RAND must not be negative");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BASIC = 3'd1,
        ST_RAND  = 3'd2,
        ST_EDGE  = 3'd3,
        ST_CLOSE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        SRC_HOLD  = 2'd0,
        SRC_BASIC = 2'd1,
        SRC_RAND  = 2'd2,
        SRC_EDGE  = 2'd3
    } src_e;

    localparam logic [XLEN-1:0] VEC_A = {1'b0, EXP'(BIAS), 1'b1, {(MANT-1){1'b0}}};
    localparam logic [XLEN-1:0] VEC_B = {1'b0, EXP'(BIAS + 1), {MANT{1'b0}}};
    localparam logic [XLEN-1:0] VEC_C = {1'b0, EXP'(BIAS + 1), 1'b1, {(MANT-1){1'b0}}};

    state_e          state_r, state_nx_s;
    src_e            src_s;
    fp_stim_phase_e  phase_r, phase_nx_s;
    logic            valid_r, valid_nx_s;
    logic            done_r, done_nx_s;
    logic [XLEN-1:0] a_r, b_r, c_r;
    logic [XLEN-1:0] a_nx_s, b_nx_s, c_nx_s;
    logic [15:0]     count_r, count_nx_s;
    logic [11:0]     edge_idx_r, edge_nx_s;
    logic            xfer_s;

`ifdef FP_STIM_SEQ_RAND_EN
    logic [31:0] rand_cnt_r, rand_cnt_nx_s;
    logic [31:0] lfsr_a_s, lfsr_b_s, lfsr_c_s;
    logic        lfsr_load_s, lfsr_adv_s;

    function automatic logic [XLEN-1:0] rand_op(input logic [31:0] s);
        return {s[31], EXP'(BIAS - 8 + int'(s[30:27])), MANT'({s, s})};
    endfunction

    fp_stim_lfsr u_lfsr_a (.clk(clk), .rst_n(rst_n), .load_i(lfsr_load_s), .seed_i(SEED),
                           .adv_i(lfsr_adv_s), .state_o(lfsr_a_s));
    fp_stim_lfsr u_lfsr_b (.clk(clk), .rst_n(rst_n), .load_i(lfsr_load_s),
                           .seed_i(SEED ^ 32'hA5A5_A5A5), .adv_i(lfsr_adv_s), .state_o(lfsr_b_s));
    fp_stim_lfsr u_lfsr_c (.clk(clk), .rst_n(rst_n), .load_i(lfsr_load_s),
                           .seed_i(SEED ^ 32'h5A5A_5A5A), .adv_i(lfsr_adv_s), .state_o(lfsr_c_s));
`endif

    assign xfer_s = valid_r & ready_i;

    // Next state, next triple source and bookkeeping; the next triple is loaded on the transfer edge.
    always_comb begin
        state_nx_s = state_r;
        valid_nx_s = valid_r;
        phase_nx_s = phase_r;
        done_nx_s  = done_r;
        edge_nx_s  = edge_idx_r;
        src_s      = SRC_HOLD;
        a_nx_s     = a_r;
        b_nx_s     = b_r;
        c_nx_s     = c_r;
`ifdef FP_STIM_SEQ_RAND_EN
        rand_cnt_nx_s = rand_cnt_r;
        lfsr_load_s   = 1'b0;
        lfsr_adv_s    = 1'b0;
`endif
        if (xfer_s && (count_r != 16'hFFFF)) begin
            count_nx_s = count_r + 16'd1;
        end else begin
            count_nx_s = count_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nx_s = ST_BASIC;
                    valid_nx_s = 1'b1;
                    phase_nx_s = PH_BASIC;
                    done_nx_s  = 1'b0;
                    count_nx_s = 16'd0;
                    edge_nx_s  = 12'd0;
                    src_s      = SRC_BASIC;
`ifdef FP_STIM_SEQ_RAND_EN
                    rand_cnt_nx_s = 32'd0;
                    lfsr_load_s   = 1'b1;
`endif
                end else begin
                    src_s = SRC_HOLD;
                end
            end
            ST_BASIC: begin
                if (xfer_s) begin
`ifdef FP_STIM_SEQ_RAND_EN
                    if (NUM_RAND != 0) begin
                        state_nx_s    = ST_RAND;
                        phase_nx_s    = PH_RAND;
                        src_s         = SRC_RAND;
                        lfsr_adv_s    = 1'b1;
                        rand_cnt_nx_s = 32'd1;
                    end else begin
                        state_nx_s = ST_EDGE;
                        phase_nx_s = PH_EDGE;
                        edge_nx_s  = 12'd0;
                        src_s      = SRC_EDGE;
                    end
`else
                    state_nx_s = ST_EDGE;
                    phase_nx_s = PH_EDGE;
                    edge_nx_s  = 12'd0;
                    src_s      = SRC_EDGE;
`endif
                end else begin
                    src_s = SRC_HOLD;
                end
            end
`ifdef FP_STIM_SEQ_RAND_EN
            ST_RAND: begin
                if (xfer_s) begin
                    if (rand_cnt_r == 32'(NUM_RAND)) begin
                        state_nx_s = ST_EDGE;
                        phase_nx_s = PH_EDGE;
                        edge_nx_s  = 12'd0;
                        src_s      = SRC_EDGE;
                    end else begin
                        src_s         = SRC_RAND;
                        lfsr_adv_s    = 1'b1;
                        rand_cnt_nx_s = rand_cnt_r + 32'd1;
                    end
                end else begin
                    src_s = SRC_HOLD;
                end
            end
`endif
            ST_EDGE: begin
                if (xfer_s) begin
                    if (edge_idx_r == 12'hFFF) begin
                        state_nx_s = ST_CLOSE;
                        phase_nx_s = PH_CLOSE;
                        src_s      = SRC_BASIC;
                    end else begin
                        edge_nx_s = edge_idx_r + 12'd1;
                        src_s     = SRC_EDGE;
                    end
                end else begin
                    src_s = SRC_HOLD;
                end
            end
            ST_CLOSE: begin
                if (xfer_s) begin
                    state_nx_s = ST_DONE;
                    valid_nx_s = 1'b0;
                    done_nx_s  = 1'b1;
                end else begin
                    src_s = SRC_HOLD;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                valid_nx_s = 1'b0;
            end
        endcase

        // The edge triple is indexed by the value the index register will take.
        case (src_s)
            SRC_BASIC: begin
                a_nx_s = VEC_A;
                b_nx_s = VEC_B;
                c_nx_s = VEC_C;
            end
`ifdef FP_STIM_SEQ_RAND_EN
            SRC_RAND: begin
                a_nx_s = rand_op(lfsr_a_s);
                b_nx_s = rand_op(lfsr_b_s);
                c_nx_s = rand_op(lfsr_c_s);
            end
`endif
            SRC_EDGE: begin
                a_nx_s = XLEN'(fp_edge_val(edge_nx_s[11:8], EXP, MANT, BIAS));
                b_nx_s = XLEN'(fp_edge_val(edge_nx_s[7:4], EXP, MANT, BIAS));
                c_nx_s = XLEN'(fp_edge_val(edge_nx_s[3:0], EXP, MANT, BIAS));
            end
            default: begin
                a_nx_s = a_r;
                b_nx_s = b_r;
                c_nx_s = c_r;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Registered outputs and sequencing counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            phase_r    <= PH_BASIC;
            a_r        <= '0;
            b_r        <= '0;
            c_r        <= '0;
            count_r    <= 16'd0;
            edge_idx_r <= 12'd0;
`ifdef FP_STIM_SEQ_RAND_EN
            rand_cnt_r <= 32'd0;
`endif
        end else begin
            valid_r    <= valid_nx_s;
            done_r     <= done_nx_s;
            phase_r    <= phase_nx_s;
            a_r        <= a_nx_s;
            b_r        <= b_nx_s;
            c_r        <= c_nx_s;
            count_r    <= count_nx_s;
            edge_idx_r <= edge_nx_s;
`ifdef FP_STIM_SEQ_RAND_EN
            rand_cnt_r <= rand_cnt_nx_s;
`endif
        end
    end

    assign valid_o = valid_r;
    assign a_o     = a_r;
    assign b_o     = b_r;
    assign c_o     = c_r;
    assign phase_o = phase_r;
    assign count_o = count_r;
    assign done_o  = done_r;

endmodule

// File: tb/tb_fp_stim_seq.sv
// Scoreboard bench for fp_stim_seq: expected triples are queued at start, a monitor pops on each transfer.
module tb_fp_stim_seq;
    import fp_stim_pkg::*;

`ifdef FP_STIM_SEQ_RAND_EN
    localparam int NR = 20;
`else
    localparam int NR = 0;
`endif
    localparam int          TOTAL  = 2 + NR + 4096;
    localparam logic [31:0] SEED_V = 32'h1;
    localparam logic [31:0] BAS_A  = 32'h3FC0_0000;
    localparam logic [31:0] BAS_B  = 32'h4000_0000;
    localparam logic [31:0] BAS_C  = 32'h4040_0000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [1:0]  ph;
    } trip_t;

    logic        clk, rst_n, start_i, ready_i, valid_o, done_o;
    logic [31:0] a_o, b_o, c_o;
    logic [1:0]  phase_o;
    logic [15:0] count_o;

    int          n_cmp, n_fail, xfer_cnt, ready_mode, stall_left;
    bit          active, stall_armed;
    trip_t       sb_q[$];
    logic [31:0] tbl [16];

    fp_stim_seq #(.XLEN(32), .EXP(8), .MANT(23), .BIAS(127), .NUM_RAND(20), .SEED(SEED_V)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .ready_i(ready_i), .valid_o(valid_o),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .phase_o(phase_o), .count_o(count_o), .done_o(done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] rnd_op(input logic [31:0] s);
        logic [7:0] e;
        e = 8'(127 - 8 + int'(s[30:27]));
        return {s[31], e, s[22:0]};
    endfunction

    task automatic push_run();
        logic [31:0] sa, sb, sc;
        sb_q.delete();
        sb_q.push_back({BAS_A, BAS_B, BAS_C, 2'd0});
        sa = SEED_V;
        sb = SEED_V ^ 32'hA5A5_A5A5;
        sc = SEED_V ^ 32'h5A5A_5A5A;
        for (int r = 0; r < NR; r++) begin
            sb_q.push_back({rnd_op(sa), rnd_op(sb), rnd_op(sc), 2'd1});
            sa = lfsr_next(sa);
            sb = lfsr_next(sb);
            sc = lfsr_next(sc);
        end
        for (int n = 0; n < 4096; n++) begin
            sb_q.push_back({tbl[n / 256], tbl[(n / 16) % 16], tbl[n % 16], 2'd2});
        end
        sb_q.push_back({BAS_A, BAS_B, BAS_C, 2'd3});
    endtask

    task automatic start_seq();
        push_run();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        xfer_cnt = 0;
        active   = 1'b1;
        check("start_latency", {valid_o, done_o, phase_o, a_o, b_o, c_o},
              {1'b1, 1'b0, 2'd0, BAS_A, BAS_B, BAS_C});
    endtask

    task automatic finish_seq(input bit stray);
        int g;
        g = 0;
        while (!done_o && g < 20000) begin
            @(negedge clk);
            g++;
            start_i = (stray && g == 300);
        end
        start_i = 1'b0;
        check("done_seen", done_o, 1'b1);
        check("end_state", {valid_o, count_o}, {1'b0, 16'(TOTAL)});
        check("sb_empty", sb_q.size(), 0);
        active = 1'b0;
    endtask

    // Ready driver: always-ready with one 5-cycle stall at edge index 100, or random.
    initial begin : driver
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1) begin
                ready_i = ($urandom_range(0, 9) < 7);
            end else if (stall_left > 0) begin
                ready_i = 1'b0;
                stall_left--;
            end else if (stall_armed && active && xfer_cnt == 1 + NR + 100) begin
                ready_i     = 1'b0;
                stall_left  = 4;
                stall_armed = 1'b0;
            end else begin
                ready_i = 1'b1;
            end
        end
    end

    // Monitor: count tracking, hold-stability under backpressure, and scoreboard pops on transfers.
    initial begin : monitor
        trip_t act_t, exp_t, held;
        bit    stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (active && rst_n) begin
                act_t = {a_o, b_o, c_o, phase_o};
                if (stalled) check("stall_hold", {valid_o, act_t}, {1'b1, held});
                check("count", count_o, 16'(xfer_cnt));
                if (valid_o && phase_o == 2'd1)
                    check("rand_exp_range",
                          {a_o[30:23] >= 8'h77 && a_o[30:23] <= 8'h86,
                           b_o[30:23] >= 8'h77 && b_o[30:23] <= 8'h86,
                           c_o[30:23] >= 8'h77 && c_o[30:23] <= 8'h86}, 3'b111);
                if (valid_o && ready_i) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_underflow: got transfer %0d expected none", xfer_cnt);
                    end else begin
                        exp_t = sb_q.pop_front();
                        check($sformatf("triple[%0d]", xfer_cnt), act_t, exp_t);
                    end
                    xfer_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = valid_o;
                    held    = act_t;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin : main
        int g;
        n_cmp = 0; n_fail = 0; xfer_cnt = 0; ready_mode = 0; stall_left = 0;
        active = 1'b0; stall_armed = 1'b0;
        rst_n = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        tbl = '{32'h0000_0000, 32'h8000_0000, 32'h007F_FFFF, 32'h0080_0000,
                32'h7F7F_FFFF, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                32'h7FA0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000,
                32'hC000_0000, 32'h3F00_0000, 32'hBF00_0000, 32'h3400_0000};
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", {valid_o, done_o, phase_o, count_o, a_o, b_o, c_o}, 128'd0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("edge_fn[%0d]", i), fp_edge_val(4'(i), 8, 23, 127), tbl[i]);
        end

        // Run 1: always ready apart from one backpressure window.
        stall_armed = 1'b1;
        ready_mode  = 0;
        start_seq();
        finish_seq(1'b0);

        // Run 2: restart from DONE, random ready, stray start mid-sequence.
        ready_mode = 1;
        start_seq();
        finish_seq(1'b1);

        // Run 3: reset partway through the edge phase.
        ready_mode = 0;
        start_seq();
        g = 0;
        while (xfer_cnt < 1 + NR + 2000 && g < 10000) begin
            @(posedge clk); #1;
            g++;
        end
        check("reached_edge_2000", xfer_cnt >= 1 + NR + 2000, 1'b1);
        rst_n  = 1'b0;
        active = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset", {valid_o, done_o, phase_o, count_o, a_o}, 128'd0);
        rst_n = 1'b1;
        sb_q.delete();

        // Run 4: fresh start after reset must reproduce the full sequence.
        ready_mode = 1;
        start_seq();
        finish_seq(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
